// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int TIMERSIZE    = 8;
    localparam int ARBSTATESIZE = 2;

    typedef enum logic [ARBSTATESIZE-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSYI = 2'd1,
        ARB_BUSYD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arbtimer.sv
// Access watchdog: counts BUSY cycles and flags when the count reaches TIMEOUT.
module arbtimer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [TIMERSIZE-1:0] ldval,
    input  logic                 en,
    output logic                 expired
);

    logic [TIMERSIZE-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      count <= '0;
        else if (clr)  count <= '0;
        else if (load) count <= ldval;
        else if (en)   count <= count + 1'b1;
    end

    assign expired = (count == TIMERSIZE'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store ports.
//   state     | meaning
//   ARB_IDLE  | no access in flight; arbitrate unmasked requests each edge
//   ARB_BUSYI | instruction read in flight, waiting for mready or timeout
//   ARB_BUSYD | data read/write in flight, waiting for mready or timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int ADDRSIZE = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ireq,
    input  logic [ADDRSIZE-1:0] iaddr,
    output logic [WORDSIZE-1:0] irdata,
    output logic                ivalid,
    output logic                ierr,
    input  logic                dreq,
    input  logic                dwe,
    input  logic [ADDRSIZE-1:0] daddr,
    input  logic [WORDSIZE-1:0] dwdata,
    output logic [WORDSIZE-1:0] drdata,
    output logic                dvalid,
    output logic                derr,
    output logic                mreq,
    output logic                mwe,
    output logic [ADDRSIZE-1:0] maddr,
    output logic [WORDSIZE-1:0] mwdata,
    input  logic [WORDSIZE-1:0] mrdata,
    input  logic                mready
);

    arb_state_t          state, state_n;
    logic                lastd, lastd_n;
    logic                mreq_n, mwe_n;
    logic [ADDRSIZE-1:0] maddr_n;
    logic [WORDSIZE-1:0] mwdata_n, irdata_n, drdata_n;
    logic                ivalid_n, dvalid_n, ierr_n, derr_n;
    logic                ireq_m, dreq_m;
    logic                t_load, t_clr, t_expired;

    // A port's request is still high during its own valid cycle; hide it so it is not granted twice.
    assign ireq_m = ireq & ~ivalid;
    assign dreq_m = dreq & ~dvalid;

    arbtimer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (t_clr),
        .load    (t_load),
        .ldval   ('0),
        .en      (state != ARB_IDLE),
        .expired (t_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB_IDLE;
            lastd  <= 1'b1;
            mreq   <= 1'b0;
            mwe    <= 1'b0;
            maddr  <= '0;
            mwdata <= '0;
            irdata <= '0;
            drdata <= '0;
            ivalid <= 1'b0;
            dvalid <= 1'b0;
            ierr   <= 1'b0;
            derr   <= 1'b0;
        end else begin
            state  <= state_n;
            lastd  <= lastd_n;
            mreq   <= mreq_n;
            mwe    <= mwe_n;
            maddr  <= maddr_n;
            mwdata <= mwdata_n;
            irdata <= irdata_n;
            drdata <= drdata_n;
            ivalid <= ivalid_n;
            dvalid <= dvalid_n;
            ierr   <= ierr_n;
            derr   <= derr_n;
        end
    end

    always_comb begin
        state_n  = state;
        lastd_n  = lastd;
        mreq_n   = mreq;
        mwe_n    = mwe;
        maddr_n  = maddr;
        mwdata_n = mwdata;
        irdata_n = irdata;
        drdata_n = drdata;
        ivalid_n = 1'b0;
        dvalid_n = 1'b0;
        ierr_n   = 1'b0;
        derr_n   = 1'b0;
        t_load   = 1'b0;
        t_clr    = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (dreq_m && (!ireq_m || !lastd)) begin
                    state_n  = ARB_BUSYD;
                    lastd_n  = 1'b1;
                    mreq_n   = 1'b1;
                    mwe_n    = dwe;
                    maddr_n  = daddr;
                    mwdata_n = dwdata;
                    t_load   = 1'b1;
                end else if (ireq_m) begin
                    state_n  = ARB_BUSYI;
                    lastd_n  = 1'b0;
                    mreq_n   = 1'b1;
                    mwe_n    = 1'b0;
                    maddr_n  = iaddr;
                    t_load   = 1'b1;
                end
            end
            ARB_BUSYI, ARB_BUSYD: begin
                // mready on the expiry edge still wins over the timeout.
                if (mready || t_expired) begin
                    state_n = ARB_IDLE;
                    mreq_n  = 1'b0;
                    mwe_n   = 1'b0;
                    t_clr   = 1'b1;
                    if (state == ARB_BUSYI) begin
                        ivalid_n = 1'b1;
                        ierr_n   = ~mready;
                        irdata_n = mready ? mrdata : '0;
                    end else begin
                        dvalid_n = 1'b1;
                        derr_n   = ~mready;
                        drdata_n = mready ? (mwe ? drdata : mrdata) : '0;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int WS = 64;
    localparam int AS = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ireq, dreq, dwe, mready;
    logic [AS-1:0] iaddr, daddr, maddr;
    logic [WS-1:0] irdata, drdata, dwdata, mwdata, mrdata;
    logic          ivalid, ierr, dvalid, derr, mreq, mwe;

    mem_arbiter #(.WORDSIZE(WS), .ADDRSIZE(AS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid), .ierr(ierr),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata),
        .dvalid(dvalid), .derr(derr),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mready(mready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference memory; unwritten words read back as an address-derived pattern.
    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    function automatic logic [63:0] raddr();
        logic [63:0] r;
        r = 64'($urandom_range(0, 15)) << 3;
        return r;
    endfunction

    // Requester bookkeeping shared with the model: a port is eligible at an edge if it has an unanswered request.
    logic pend_i = 1'b0, pend_d = 1'b0;
    logic elig_i_q = 1'b0, elig_d_q = 1'b0;
    always @(posedge clk) begin
        elig_i_q <= pend_i;
        elig_d_q <= pend_d;
    end

    int          force_d = -1;
    int          phase, n, d;
    logic        a_port, a_we, m_we, last_d, exp_err;
    logic [63:0] a_addr, m_addr, m_wdata, exp_irdata, exp_drdata;

    // Memory responder and transaction-level arbitration model.
    initial begin : mem_model
        logic want_d, want_any;
        mready = 1'b0;
        mrdata = '0;
        phase = 0; last_d = 1'b1; exp_irdata = '0; exp_drdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = 0; last_d = 1'b1; exp_irdata = '0; exp_drdata = '0; mready = 1'b0;
            end else if (phase == 2) begin
                mready = 1'b0;
                chk("mreq_gap", 64'(mreq), 64'd0);
                chk("ivalid", 64'(ivalid), 64'(!a_port));
                chk("dvalid", 64'(dvalid), 64'(a_port));
                if (a_port) chk("derr", 64'(derr), 64'(exp_err));
                else        chk("ierr", 64'(ierr), 64'(exp_err));
                chk("irdata", irdata, exp_irdata);
                chk("drdata", drdata, exp_drdata);
                phase = 0;
            end else begin
                if (phase == 0) begin
                    want_any = elig_i_q || elig_d_q;
                    want_d   = elig_d_q && (!elig_i_q || !last_d);
                    chk("stray_valid", 64'({ivalid, dvalid}), 64'd0);
                    chk("grant", 64'(mreq), 64'(want_any));
                    if (mreq) begin
                        a_port  = want_d;
                        a_addr  = want_d ? daddr : iaddr;
                        a_we    = want_d ? dwe : 1'b0;
                        m_addr  = maddr;
                        m_we    = mwe;
                        m_wdata = mwdata;
                        chk("grant_addr", maddr, a_addr);
                        chk("grant_we", 64'(mwe), 64'(a_we));
                        if (a_we) chk("grant_wdata", mwdata, dwdata);
                        last_d = want_d;
                        d = (force_d >= 0) ? force_d : int'($urandom_range(0, TO + 2));
                        n = 0;
                        phase = 1;
                    end
                end
                if (phase == 1) begin
                    chk("mreq_hold", 64'(mreq), 64'd1);
                    mready = (n == d);
                    mrdata = (mready && !m_we) ? mem_rd(m_addr) : {$urandom, $urandom};
                    if (n == d || n == TO) begin
                        exp_err = (n != d);
                        if (a_port) exp_drdata = exp_err ? 64'd0 : (a_we ? exp_drdata : mem_rd(a_addr));
                        else        exp_irdata = exp_err ? 64'd0 : mem_rd(a_addr);
                        if (!exp_err && m_we) ref_mem[m_addr] = m_wdata;
                        phase = 2;
                    end
                    n++;
                end
            end
        end
    end

    logic [63:0] i_last_rdata, d_last_rdata;
    logic        i_last_err, d_last_err;
    time         i_last_t, d_last_t;
    int          d_last_lat;

    task automatic issue_i(input logic [63:0] a);
        bit got = 0;
        iaddr = a; ireq = 1'b1; pend_i = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (ivalid) begin
                got = 1; i_last_rdata = irdata; i_last_err = ierr; i_last_t = $time;
            end
        end
        pend_i = 1'b0;
        chk("i_done", 64'(got), 64'd1);
        @(posedge clk); #1;
        ireq = 1'b0;
    endtask

    task automatic issue_d(input logic we, input logic [63:0] a, input logic [63:0] wd);
        bit  got = 0;
        time t0;
        t0 = $time;
        daddr = a; dwe = we; dwdata = wd; dreq = 1'b1; pend_d = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (dvalid) begin
                got = 1; d_last_rdata = drdata; d_last_err = derr; d_last_t = $time;
                d_last_lat = int'(($time - t0 + 4) / 10);
            end
        end
        pend_d = 1'b0;
        chk("d_done", 64'(got), 64'd1);
        @(posedge clk); #1;
        dreq = 1'b0; dwe = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctrl", 64'({mreq, mwe, ivalid, dvalid, ierr, derr}), 64'd0);
        chk("rst_maddr", maddr, 64'd0);
        chk("rst_mwdata", mwdata, 64'd0);
        chk("rst_irdata", irdata, 64'd0);
        chk("rst_drdata", drdata, 64'd0);
    endtask

    initial begin : main
        bit got;
        ireq = 0; dreq = 0; dwe = 0; iaddr = '0; daddr = '0; dwdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        ref_mem[64'h40] = 64'hD503201F;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // tie right after reset: instruction port first
        force_d = 1;
        fork
            issue_i(64'h80);
            issue_d(1'b0, 64'h88, 64'd0);
        join
        chk("tie_order", 64'(i_last_t < d_last_t), 64'd1);

        issue_i(64'h40);
        chk("fetch_data", i_last_rdata, 64'hD503201F);
        chk("fetch_err", 64'(i_last_err), 64'd0);

        force_d = 0;
        issue_d(1'b1, 64'h100, 64'hCAFE);
        chk("store_err", 64'(d_last_err), 64'd0);
        chk("store_keep", d_last_rdata, mem_rd(64'h88) == 64'hCAFE ? 64'hCAFE : {32'h5A5A_0F0F ^ 32'h88, ~32'h88});
        chk("min_latency", 64'(d_last_lat), 64'd2);
        force_d = 1;
        issue_d(1'b0, 64'h100, 64'd0);
        chk("store_readback", d_last_rdata, 64'hCAFE);

        force_d = TO + 1;
        issue_d(1'b0, 64'h40, 64'd0);
        chk("to_err", 64'(d_last_err), 64'd1);
        chk("to_data", d_last_rdata, 64'd0);
        chk("to_latency", 64'(d_last_lat), 64'(TO + 2));
        force_d = TO;
        issue_d(1'b0, 64'h40, 64'd0);
        chk("edge_err", 64'(d_last_err), 64'd0);
        chk("edge_data", d_last_rdata, 64'hD503201F);

        // sustained contention, then random traffic
        force_d = -1;
        fork
            begin repeat (3) issue_i(raddr()); end
            begin repeat (3) issue_d(1'($urandom_range(0, 1)), raddr(), {$urandom, $urandom}); end
        join
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    issue_i(raddr());
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    issue_d(1'($urandom_range(0, 1)), raddr(), {$urandom, $urandom});
                end
            end
        join

        // reset in the middle of a store
        force_d = 99;
        daddr = 64'h100; dwe = 1'b1; dwdata = 64'h1234; dreq = 1'b1; pend_d = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = mreq;
        end
        chk("rst_mid_mreq", 64'(got), 64'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        dreq = 1'b0; dwe = 1'b0; pend_d = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        force_d = 0;
        @(posedge clk); #1;
        fork
            issue_i(64'h10);
            issue_d(1'b0, 64'h18, 64'd0);
        join
        chk("tie_after_rst", 64'(i_last_t < d_last_t), 64'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
